// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word requests over a req/ack handshake and
// buffers returned {instr, pc} pairs in a small FIFO for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] stale_pc, stale_pc_next;
  logic [31:0] addr_q, addr_next;
  logic        req_q;

  logic [CW-1:0] count, count_next, count_after_pop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem    [FIFO_DEPTH];

  logic        push, pop, flush;
  logic [31:0] redir_pc;

  assign redir_pc        = redirect_pc & ~32'h0000_0003;
  assign pop             = (count != '0) && !stall;
  assign count_after_pop = count - CW'(pop);

  // Next-state logic: a request is only started when a slot is guaranteed free,
  // so a push can never land on a full FIFO.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    stale_pc_next = stale_pc;
    push          = 1'b0;
    flush         = 1'b0;

    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          flush         = 1'b1;
          fetch_pc_next = redir_pc;
        end else if (count_after_pop < DEPTH_C) begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_ack && redirect_valid) begin
          flush         = 1'b1;
          fetch_pc_next = redir_pc;
          state_next    = S_FETCH;
        end else if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + 32'd4;
          state_next    = ((count_after_pop + CW'(1)) < DEPTH_C) ? S_FETCH : S_IDLE;
        end else if (redirect_valid) begin
          // The outstanding request cannot be withdrawn; drain its response.
          flush         = 1'b1;
          stale_pc_next = fetch_pc;
          fetch_pc_next = redir_pc;
          state_next    = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (redirect_valid) begin
          flush         = 1'b1;
          fetch_pc_next = redir_pc;
        end
        if (imem_ack) begin
          state_next = S_FETCH;
        end
      end

      default: state_next = S_IDLE;
    endcase

    count_next = flush ? '0 : (count_after_pop + CW'(push));
    addr_next  = (state_next == S_DRAIN) ? stale_pc_next : fetch_pc_next;
  end

  // Control and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      stale_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      req_q    <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      stale_pc <= stale_pc_next;
      addr_q   <= addr_next;
      req_q    <= (state_next != S_IDLE);
      count    <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage: data only, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? instr_mem[rd_ptr] : NOP;
  assign pc_out      = instr_valid ? pc_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table of inputs/expected outputs,
// followed by a random-stall streaming sequence with an in-order PC model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        ack_en;

  localparam logic [31:0] TAG = 32'hE000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory model: answers in the request cycle when enabled; word = addr ^ TAG
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = imem_addr ^ TAG;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .pc_out(pc_out)
  );

  typedef struct {
    bit          rst;
    bit          ack;
    bit          stall;
    bit          rdv;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, bit a, bit s, bit d, logic [31:0] rp,
                             bit q, logic [31:0] ad, bit vl, logic [31:0] p);
    vec_t t;
    t.rst = r; t.ack = a; t.stall = s; t.rdv = d; t.rpc = rp;
    t.req = q; t.addr = ad; t.vld = vl; t.pc = p;
    return t;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
    end
  endtask

  initial begin
    int exp_pc;
    int pops;

    rst = 1'b1; ack_en = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    //           rst ack stl rdv rpc           req addr          vld pc
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         1, 32'h8,         1, 32'h4));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'hC,         1, 32'h4));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'hC,         1, 32'h4));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'hC,         1, 32'h4));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'hC,         1, 32'h4));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         0, 32'hC,         1, 32'h4));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'hC,         1, 32'h8));
    tbl.push_back(v(0, 1, 0, 1, 32'h203,       1, 32'h10,        1, 32'hC));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h200,       0, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,         1, 32'h204,       1, 32'h200));
    tbl.push_back(v(0, 0, 0, 1, 32'h100,       1, 32'h204,       0, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 32'h40,        1, 32'h204,       0, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 32'h80,        1, 32'h204,       0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h204,       0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h80,        0, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         1, 32'h84,        1, 32'h80));
    tbl.push_back(v(1, 1, 1, 0, 32'h0,         0, 32'h88,        1, 32'h80));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,         1, 32'h4,         1, 32'h0));
    tbl.push_back(v(1, 1, 0, 0, 32'h0,         1, 32'h4,         0, 32'h0));
    tbl.push_back(v(0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFFC));
    tbl.push_back(v(0, 1, 1, 1, 32'h300,       0, 32'h4,         1, 32'hFFFF_FFFC));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         0, 32'h300,       0, 32'h0));
    tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h300,       0, 32'h0));

    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst            = tbl[i].rst;
      ack_en         = tbl[i].ack;
      stall          = tbl[i].stall;
      redirect_valid = tbl[i].rdv;
      redirect_pc    = tbl[i].rpc;
      chk("imem_req",    i, {31'h0, imem_req},    {31'h0, tbl[i].req});
      chk("imem_addr",   i, imem_addr,            tbl[i].addr);
      chk("instr_valid", i, {31'h0, instr_valid}, {31'h0, tbl[i].vld});
      chk("pc_out",      i, pc_out,               tbl[i].pc);
      chk("instr",       i, instr,                tbl[i].vld ? (tbl[i].pc ^ TAG) : NOP);
    end

    // Streaming with random stalls: every popped entry must be the next PC in order
    @(negedge clk);
    rst = 1'b1; ack_en = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 0;
    pops   = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      if (instr_valid && !stall) begin
        chk("stream_pc",    1000 + c, pc_out, 32'(exp_pc));
        chk("stream_instr", 1000 + c, instr,  32'(exp_pc) ^ TAG);
        exp_pc += 4;
        pops++;
      end
    end
    chk("stream_progress", 2000, {31'h0, pops >= 15}, 32'h1);

    // Full-rate stream: with stall low the head advances one PC per cycle
    @(negedge clk);
    stall = 1'b0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      chk("rate_valid", 3000 + c, {31'h0, instr_valid}, 32'h1);
      if (c > 0) chk("rate_step", 3000 + c, pc_out, 32'(exp_pc) + 32'd4);
      exp_pc = int'(pc_out);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
